// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and parameter defaults for debounce_sync.
// The state encoding keeps bit 1 equal to the level currently reported on dout.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        PEND_HI   = 2'b01,
        STABLE_HI = 2'b11,
        PEND_LO   = 2'b10
    } db_state_e;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop chain that brings an asynchronous level into
// the clk domain. Asynchronous active-low reset clears every stage to 0.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_chain: STAGES must be >= 2");
    end

    logic [STAGES-1:0] chain_q;

    // Shift the raw input one stage deeper each clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: synchronizes a noisy asynchronous level and only changes dout
// after DEBOUNCE_CYCLES consecutive synchronized samples at the new level.
// Optional feature macro DEBOUNCE_SYNC_EDGE_EN: when defined, registered
// one-cycle rise/fall strobes accompany every dout change; when undefined the
// strobe ports are tied to 0 and no edge flops exist.
import debounce_pkg::*;

module debounce_sync #(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din_raw,
    output logic dout,
    output logic rise_pulse,
    output logic fall_pulse
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_sync: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
        $error("debounce_sync: DEBOUNCE_CYCLES must be >= 2");
    end

    // The counter only ever reaches DEBOUNCE_CYCLES-1, so this width never wraps.
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (din_raw),
        .q    (s)
    );

    // Next-state logic: a pending state counts agreeing samples and falls back
    // to its stable state on the first disagreeing one (glitch rejected).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    dout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and debounced output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

`ifdef DEBOUNCE_SYNC_EDGE_EN
    logic rise_q, fall_q;

    // Strobes load in the same edge as dout so they coincide with its first new cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= dout_d & ~dout_q;
            fall_q <= ~dout_d & dout_q;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Strobe expectations follow DEBOUNCE_SYNC_EDGE_EN: zero when it is undefined.
`timescale 1ns/1ps
module tb_debounce_sync;
    import debounce_pkg::*;

    localparam int SYNC = 2;
    localparam int DC   = 4;
`ifdef DEBOUNCE_SYNC_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic din_raw = 1'b0;
    logic dout, rise_pulse, fall_pulse;

    int errors = 0;
    int checks = 0;

    // Reference model: samples reach the debouncer SYNC edges after capture;
    // dout flips once DC consecutive delivered samples disagree with it.
    bit sync_m[$];
    bit dout_m, rise_m, fall_m;
    int run_m;

    always #5 clk = ~clk;

    debounce_sync #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din_raw   (din_raw),
        .dout      (dout),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    task automatic model_reset();
        sync_m.delete();
        for (int i = 0; i < SYNC; i++) sync_m.push_back(1'b0);
        dout_m = 1'b0;
        rise_m = 1'b0;
        fall_m = 1'b0;
        run_m  = 0;
    endtask

    // Drive one input value for one clock, advance the model, settle 1ns past the edge.
    task automatic step(input bit d);
        bit x;
        din_raw = d;
        @(posedge clk);
        if (reset) begin
            x = sync_m.pop_front();
            sync_m.push_back(d);
            rise_m = 1'b0;
            fall_m = 1'b0;
            if (x != dout_m) begin
                run_m++;
                if (run_m == DC) begin
                    dout_m = x;
                    run_m  = 0;
                    rise_m = EDGE_EN & x;
                    fall_m = EDGE_EN & !x;
                end
            end else begin
                run_m = 0;
            end
        end
        #1;
    endtask

    task automatic settle(input bit d, input int n);
        for (int i = 0; i < n; i++) step(d);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1'b1);
            checks++;
            if (dout !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: dout=%b rise=%b fall=%b required 0/0/0",
                         i, dout, rise_pulse, fall_pulse);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1);
            checks++;
            if (dout !== (i >= 6) || rise_pulse !== (EDGE_EN && i == 6) || fall_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_release edge%0d: dout=%b rise=%b fall=%b required %b/%b/0",
                         i, dout, rise_pulse, fall_pulse, (i >= 6), (EDGE_EN && i == 6));
            end
        end
    endtask

    task automatic test_clean_fall();
        for (int i = 1; i <= 7; i++) begin
            step(1'b0);
            checks++;
            if (dout !== (i < 6) || fall_pulse !== (EDGE_EN && i == 6) || rise_pulse !== 1'b0) begin
                errors++;
                $display("FAIL clean_fall edge%0d: dout=%b rise=%b fall=%b required %b/0/%b",
                         i, dout, rise_pulse, fall_pulse, (i < 6), (EDGE_EN && i == 6));
            end
        end
    endtask

    task automatic test_clean_rise();
        for (int i = 1; i <= 7; i++) begin
            step(1'b1);
            checks++;
            if (dout !== (i >= 6) || rise_pulse !== (EDGE_EN && i == 6) || fall_pulse !== 1'b0) begin
                errors++;
                $display("FAIL clean_rise edge%0d: dout=%b rise=%b fall=%b required %b/%b/0",
                         i, dout, rise_pulse, fall_pulse, (i >= 6), (EDGE_EN && i == 6));
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 1; i <= 20; i++) begin
            step(i <= 3);
            checks++;
            if (dout !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
                errors++;
                $display("FAIL glitch cyc%0d: dout=%b rise=%b fall=%b required 0/0/0",
                         i, dout, rise_pulse, fall_pulse);
            end
        end
    endtask

    task automatic test_bounce();
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int rises = 0;
        // The last 0->1 is applied at step 6, so dout must rise at step 6+5=11.
        for (int k = 1; k <= 14; k++) begin
            step((k <= 6) ? pat[k-1] : 1'b1);
            if (rise_pulse === 1'b1) rises++;
            checks++;
            if (dout !== (k >= 11) || rise_pulse !== (EDGE_EN && k == 11) || fall_pulse !== 1'b0) begin
                errors++;
                $display("FAIL bounce step%0d: dout=%b rise=%b fall=%b required %b/%b/0",
                         k, dout, rise_pulse, fall_pulse, (k >= 11), (EDGE_EN && k == 11));
            end
        end
        checks++;
        if (rises != (EDGE_EN ? 1 : 0)) begin
            errors++;
            $display("FAIL bounce_rise_count: got %0d required %0d", rises, (EDGE_EN ? 1 : 0));
        end
    endtask

    task automatic test_reset_mid();
        settle(1'b0, 10);
        for (int i = 0; i < 4; i++) step(1'b1);
        checks++;
        if (dut.state_q !== PEND_HI || dut.cnt_q !== 2'd2) begin
            errors++;
            $display("FAIL reset_mid_pre: state=%b cnt=%0d required 01/2", dut.state_q, dut.cnt_q);
        end
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut.state_q !== STABLE_LO || dout !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_now: state=%b dout=%b rise=%b fall=%b required 00/0/0/0",
                     dut.state_q, dout, rise_pulse, fall_pulse);
        end
        for (int i = 1; i <= 3; i++) begin
            step(1'b1);
            checks++;
            if (dout !== 1'b0 || rise_pulse !== 1'b0 || fall_pulse !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_hold cyc%0d: dout=%b rise=%b fall=%b required 0/0/0",
                         i, dout, rise_pulse, fall_pulse);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1'b1);
            checks++;
            if (dout !== (i >= 6) || rise_pulse !== (EDGE_EN && i == 6)) begin
                errors++;
                $display("FAIL reset_mid_release edge%0d: dout=%b rise=%b required %b/%b",
                         i, dout, rise_pulse, (i >= 6), (EDGE_EN && i == 6));
            end
        end
    endtask

    task automatic test_random();
        bit d = 1'b0;
        int seg = 0;
        int rst_left = 0;
        for (int i = 0; i < 600; i++) begin
            if (seg == 0) begin
                d   = 1'($urandom_range(0, 1));
                seg = $urandom_range(1, 8);
            end
            seg--;
            if (reset && $urandom_range(0, 149) == 0) begin
                reset = 1'b0;
                model_reset();
                rst_left = 2;
            end else if (!reset) begin
                if (rst_left == 0) reset = 1'b1;
                else rst_left--;
            end
            step(d);
            checks++;
            if (dout !== dout_m || rise_pulse !== rise_m || fall_pulse !== fall_m) begin
                errors++;
                $display("FAIL random cyc%0d: dout=%b rise=%b fall=%b required %b/%b/%b",
                         i, dout, rise_pulse, fall_pulse, dout_m, rise_m, fall_m);
            end
            checks++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
                errors++;
                $display("FAIL random_overlap cyc%0d: rise=1 fall=1 required not both", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_fall();
        test_clean_rise();
        settle(1'b0, 10);
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
